// File: rtl/sprite_motion.sv
// Per-frame sprite mover: keycode-driven direction, held-key speed ramp, pause,
// and a configurable wall response (bounce / stop / wrap) with a one-frame hit pulse.
module sprite_motion #(
    parameter int          W           = 10,
    parameter int          X_CENTER    = 400,
    parameter int          Y_CENTER    = 250,
    parameter int          X_MIN       = 270,
    parameter int          X_MAX       = 600,
    parameter int          Y_MIN       = 50,
    parameter int          Y_MAX       = 400,
    parameter int          SIZE        = 4,
    parameter int          STEP_MAX    = 4,
    parameter int          RAMP_FRAMES = 8,
    parameter int          EDGE_MODE   = 0,
    parameter logic [7:0]  KEY_UP      = 8'h52,
    parameter logic [7:0]  KEY_DOWN    = 8'h51,
    parameter logic [7:0]  KEY_LEFT    = 8'h50,
    parameter logic [7:0]  KEY_RIGHT   = 8'h4F
) (
    input  logic         frame_clk,
    input  logic         Reset,
    input  logic [7:0]   key,
    input  logic         pause,
    output logic [W-1:0] SpriteX,
    output logic [W-1:0] SpriteY,
    output logic [W-1:0] SpriteS,
    output logic [1:0]   Dir,
    output logic [2:0]   Speed,
    output logic         moving,
    output logic         hit
);
    localparam int RW = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_FRAMES - 1);
    localparam logic [2:0]    SPEED_MAX = 3'(STEP_MAX);
    localparam logic signed [W+1:0] X_LO = (W+2)'(X_MIN + SIZE);
    localparam logic signed [W+1:0] X_HI = (W+2)'(X_MAX - SIZE);
    localparam logic signed [W+1:0] Y_LO = (W+2)'(Y_MIN + SIZE);
    localparam logic signed [W+1:0] Y_HI = (W+2)'(Y_MAX - SIZE);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_PAUSED} state_t;

    state_t          state_reg, state_next, ret_reg, ret_next, eff_state;
    logic [W-1:0]    x_reg, x_next, y_reg, y_next;
    logic [1:0]      dir_reg, dir_next;
    logic [2:0]      speed_reg, speed_next;
    logic [RW-1:0]   ramp_reg, ramp_next;
    logic            hit_reg, hit_next;

    logic            key_valid;
    logic [1:0]      key_dir;
    logic            stepping, axis_x, wall;
    logic [W-1:0]    new_pos;
    logic signed [W+1:0] pos_s, spd_s, lo_s, hi_s, n;

    always_comb begin
        key_valid = 1'b1;
        key_dir   = 2'd0;
        if (key == KEY_UP)         key_dir = 2'd0;
        else if (key == KEY_DOWN)  key_dir = 2'd1;
        else if (key == KEY_LEFT)  key_dir = 2'd2;
        else if (key == KEY_RIGHT) key_dir = 2'd3;
        else                       key_valid = 1'b0;
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_reg <= S_IDLE;
            ret_reg   <= S_IDLE;
            x_reg     <= W'(X_CENTER);
            y_reg     <= W'(Y_CENTER);
            dir_reg   <= 2'd0;
            speed_reg <= 3'd0;
            ramp_reg  <= '0;
            hit_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ret_reg   <= ret_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            dir_reg   <= dir_next;
            speed_reg <= speed_next;
            ramp_reg  <= ramp_next;
            hit_reg   <= hit_next;
        end
    end

    always_comb begin
        // Releasing pause resumes on this same edge as if never paused.
        eff_state  = (state_reg == S_PAUSED && !pause) ? ret_reg : state_reg;
        state_next = eff_state;
        ret_next   = ret_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        dir_next   = dir_reg;
        speed_next = speed_reg;
        ramp_next  = ramp_reg;
        hit_next   = 1'b0;
        stepping   = 1'b0;

        case (eff_state)
            S_IDLE: begin
                if (pause) begin
                    state_next = S_PAUSED;
                    ret_next   = S_IDLE;
                end else if (key_valid) begin
                    dir_next   = key_dir;
                    speed_next = 3'd1;
                    ramp_next  = '0;
                    stepping   = 1'b1;
                end
            end
            S_MOVE: begin
                if (pause) begin
                    state_next = S_PAUSED;
                    ret_next   = S_MOVE;
                end else begin
                    stepping = 1'b1;
                    if (!key_valid) begin
                        ramp_next = '0;
                    end else if (key_dir != dir_reg) begin
                        dir_next   = key_dir;
                        speed_next = 3'd1;
                        ramp_next  = '0;
                    end else if (ramp_reg == RAMP_LAST) begin
                        ramp_next = '0;
                        if (speed_reg < SPEED_MAX)
                            speed_next = speed_reg + 3'd1;
                    end else begin
                        ramp_next = ramp_reg + RW'(1);
                    end
                end
            end
            default: ;
        endcase

        // Wall check uses the direction and speed resolved above.
        axis_x  = dir_next[1];
        pos_s   = $signed({2'b00, (axis_x ? x_reg : y_reg)});
        spd_s   = $signed({{(W-1){1'b0}}, speed_next});
        lo_s    = axis_x ? X_LO : Y_LO;
        hi_s    = axis_x ? X_HI : Y_HI;
        n       = dir_next[0] ? (pos_s + spd_s) : (pos_s - spd_s);
        wall    = (n > hi_s) || (n < lo_s);
        new_pos = n[W-1:0];

        if (stepping) begin
            state_next = S_MOVE;
            if (wall) begin
                hit_next = 1'b1;
                if (EDGE_MODE == 1) begin
                    new_pos    = (n > hi_s) ? hi_s[W-1:0] : lo_s[W-1:0];
                    speed_next = 3'd0;
                    ramp_next  = '0;
                    state_next = S_IDLE;
                end else if (EDGE_MODE == 2) begin
                    new_pos = (n > hi_s) ? lo_s[W-1:0] : hi_s[W-1:0];
                end else begin
                    new_pos  = (n > hi_s) ? hi_s[W-1:0] : lo_s[W-1:0];
                    dir_next = dir_next ^ 2'b01;
                end
            end
            if (axis_x) x_next = new_pos;
            else        y_next = new_pos;
        end
    end

    always_comb begin
        SpriteX = x_reg;
        SpriteY = y_reg;
        SpriteS = W'(SIZE);
        Dir     = dir_reg;
        Speed   = speed_reg;
        moving  = (state_reg == S_MOVE);
        hit     = hit_reg;
    end
endmodule

// File: doc/sprite_motion.md
# sprite_motion

Parametrised successor to the single-ball mover in the USB/VGA lab design. It updates one sprite's position once per frame from the keyboard keycode. It adds:
- a configurable play-field, sprite size and keycodes;
- a speed ramp while a direction key is held;
- three edge modes: bounce, stop and wrap;
- pause;
- a wall-hit pulse.

Motion is resolved and applied on the same edge, so there is no one-frame lag between a key or bounce and the position step. Outputs feed the colour mapper directly.

## Interface
Parameters:
- W, 10, coordinate width
- X_CENTER, 400, reset X
- Y_CENTER, 250, reset Y
- X_MIN, 270, left field bound
- X_MAX, 600, right field bound
- Y_MIN, 50, top field bound
- Y_MAX, 400, bottom field bound
- SIZE, 4, sprite half-size
- STEP_MAX, 4, maximum speed in pixels/frame (≥1, < SIZE*2)
- RAMP_FRAMES, 8, held-key frames per speed increment (≥1)
- EDGE_MODE, 0, 0 = bounce, 1 = stop, 2 = wrap
- KEY_UP, 8'h52, up keycode
- KEY_DOWN, 8'h51, down keycode
- KEY_LEFT, 8'h50, left keycode
- KEY_RIGHT, 8'h4F, right keycode

Ports:
- frame_clk  in  1  frame clock (vsync-derived), the only clock
- Reset  in  1  synchronous, active-high
- key  in  8  current keycode; any non-direction value means no key
- pause  in  1  freeze motion while high
- SpriteX  out  W  sprite centre X
- SpriteY  out  W  sprite centre Y
- SpriteS  out  W  constant SIZE
- Dir  out  2  direction: 0 up, 1 down, 2 left, 3 right
- Speed  out  3  current step in pixels/frame, 0..STEP_MAX
- moving  out  1  high in MOVE state
- hit  out  1  one-frame pulse on a wall event

## Operation
- Legal centre range:
  - X_LO = X_MIN+SIZE, X_HI = X_MAX−SIZE (defaults 274..596).
  - Y_LO = Y_MIN+SIZE, Y_HI = Y_MAX−SIZE (defaults 54..396).
- States:
  - IDLE: stationary. Entered on reset and on a stop-mode wall hit.
  - MOVE: stepping each frame.
  - PAUSED: frozen.
- Transitions:
  - IDLE → MOVE on a direction key: Dir = key direction, Speed = 1, step applied on the same edge.
  - MOVE → PAUSED and IDLE → PAUSED when pause = 1.
  - PAUSED → the state it came from when pause = 0.
  - PAUSED ignores keys. Ramp counter and position hold.
- Key handling in MOVE:
  - Key equal to Dir: ramp_cnt increments. At RAMP_FRAMES−1 with Speed < STEP_MAX, Speed += 1 and ramp_cnt = 0. At STEP_MAX, Speed saturates.
  - Key not equal to Dir, including a reversal: Dir = new direction, Speed = 1, ramp_cnt = 0.
  - No key: ramp_cnt = 0. Dir and Speed are kept and the sprite keeps moving.
- Step computation:
  - Next position: n = pos ± Speed on the Dir axis, evaluated in W+2-bit signed arithmetic so underflow is detected.
  - Uses the Dir/Speed resolved this edge.
  - The other axis is unchanged.
- Wall event (n > HI or n < LO on the active axis), hit = 1:
  - Bounce: pos = violated bound (HI or LO). Dir reverses on the same axis. Speed kept.
  - Stop: pos = violated bound. Speed = 0. State = IDLE.
  - Wrap: pos = opposite bound (LO when n > HI, HI when n < LO). Dir and Speed kept.
- Pressing toward a wall while at the bound: the key is applied first, then the wall check. In bounce mode this gives an immediate reversal back onto the bound.
- Otherwise pos = n and hit = 0.

## Timing
- All outputs are registered and change only on the frame_clk rising edge.
- Key sampled at edge k affects SpriteX/SpriteY at edge k (zero-frame latency).
- hit is high for exactly the one frame following the event edge.
- Reset (any state, including PAUSED or mid-ramp) at the edge gives:
  - SpriteX = X_CENTER, SpriteY = Y_CENTER, SpriteS = SIZE;
  - Dir = 0, Speed = 0, moving = 0, hit = 0;
  - ramp_cnt = 0, state = IDLE.
- Reset has priority over pause and key.
- pause and Reset asserted together: reset wins and the block is in IDLE afterwards.

## Test plan
- Reset then KEY_UP for 1 frame, then no key for 3 frames → SpriteY 249, 248, 247, 246; SpriteX 400; Speed 1; moving 1.
- Hold KEY_RIGHT 25 frames from reset → Speed 1 for frames 1–8, 2 for 9–16, 3 for 17–24, 4 at frame 25. SpriteX steps match the running sum.
- Bounce: X = 595, Speed 2, Dir right → X = 596, Dir left, hit = 1 for one frame; next frame X = 594.
- EDGE_MODE = 1: Y = 55, Dir up, Speed 3 → Y = 54, Speed 0, moving 0, hit pulse. A later KEY_DOWN gives Y = 55.
- EDGE_MODE = 2: X = 275, Dir left, Speed 2 → X = 596, Dir left, hit pulse. pause = 1 for 5 frames holds all outputs; release resumes at X = 594.
- Reset asserted mid-ramp while paused → outputs at reset values next frame; KEY_LEFT then gives X = 399, Speed 1.
